// File: rtl/uart_rx_core_if.sv
// rtl/uart_rx_core_if.sv - serial line, frame config and received-byte bundle for uart_rx_core
interface uart_rx_core_if;
    logic       uart_rx;
    logic [1:0] cfg_parity;
    logic [1:0] cfg_stop_bits;
    logic [7:0] rxdout;
    logic       rxvalid;
    logic       parity_err;
    logic       frame_err;

    // Environment side: drives the line and config, consumes bytes
    modport master (
        output uart_rx,
        output cfg_parity,
        output cfg_stop_bits,
        input  rxdout,
        input  rxvalid,
        input  parity_err,
        input  frame_err
    );

    // Receiver side
    modport slave (
        input  uart_rx,
        input  cfg_parity,
        input  cfg_stop_bits,
        output rxdout,
        output rxvalid,
        output parity_err,
        output frame_err
    );
endinterface

// File: rtl/uart_rx_core.sv
// rtl/uart_rx_core.sv - 16x oversampled UART receiver, 8 data bits LSB first, optional parity
module uart_rx_core #(
    parameter int BUADRATE = 115200,
    parameter int CLKFRQ   = 100
) (
    input  logic          clk,
    input  logic          rst,
    uart_rx_core_if.slave bus
);
    localparam int SAMPLE_RATE  = 16;
    localparam int SAMPLE_COUNT = CLKFRQ * 1000000 / (BUADRATE * SAMPLE_RATE);
    localparam logic [15:0] SAMPLE_MAX = 16'(SAMPLE_COUNT);

    typedef enum logic [4:0] {
        IDLE   = 5'b00001,
        START  = 5'b00010,
        DATA   = 5'b00100,
        PARITY = 5'b01000,
        STOP   = 5'b10000
    } state_t;

    state_t      state, state_nxt;
    logic        rx_meta, rx_s, rx_d;
    logic        fall;
    logic [15:0] baud_cnt;
    logic        tick;
    logic [4:0]  sample_cnt;
    logic [2:0]  bit_cnt;
    logic [7:0]  shreg;
    logic        perr;
    logic        data_smp, par_smp, stop_smp;

    // Stop-bit count only shapes idle time on the line; the receiver never needs it
    logic unused_cfg;
    assign unused_cfg = ^bus.cfg_stop_bits;

    // Two-flop synchroniser plus a delay flop for edge detection; idle high
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_d    <= 1'b1;
        end else begin
            rx_meta <= bus.uart_rx;
            rx_s    <= rx_meta;
            rx_d    <= rx_s;
        end
    end

    assign fall = rx_d & ~rx_s;

    // Oversample tick generator, parked at zero while idle so ticks align to the start edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            baud_cnt <= '0;
        end else if (state == IDLE || baud_cnt == SAMPLE_MAX) begin
            baud_cnt <= '0;
        end else begin
            baud_cnt <= baud_cnt + 16'd1;
        end
    end

    assign tick = (state != IDLE) && (baud_cnt == SAMPLE_MAX);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and mid-bit sample strobes
    always_comb begin
        state_nxt = state;
        data_smp  = 1'b0;
        par_smp   = 1'b0;
        stop_smp  = 1'b0;
        case (state)
            IDLE: begin
                if (fall) state_nxt = START;
            end
            START: begin
                if (tick && sample_cnt == 5'd7) state_nxt = rx_s ? IDLE : DATA;
            end
            DATA: begin
                if (tick && sample_cnt == 5'd15) begin
                    data_smp = 1'b1;
                    if (bit_cnt == 3'd7) state_nxt = bus.cfg_parity[0] ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (tick && sample_cnt == 5'd15) begin
                    par_smp   = 1'b1;
                    state_nxt = STOP;
                end
            end
            STOP: begin
                if (tick && sample_cnt == 5'd15) begin
                    stop_smp  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Tick counter within a bit; restarts on every state change and after each data sample
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample_cnt <= '0;
        end else if (state_nxt != state || data_smp) begin
            sample_cnt <= '0;
        end else if (tick) begin
            sample_cnt <= sample_cnt + 5'd1;
        end
    end

    // Data bit counter, live only in DATA
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt <= '0;
        end else if (state != DATA) begin
            bit_cnt <= '0;
        end else if (data_smp) begin
            bit_cnt <= bit_cnt + 3'd1;
        end
    end

    // Right-shift register: first bit received ends up in bit 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg <= '0;
        end else if (data_smp) begin
            shreg <= {rx_s, shreg[7:1]};
        end
    end

    // Parity check: even parity sums to 0 over data+parity, odd flips the sense
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perr <= 1'b0;
        end else if (par_smp) begin
            perr <= rx_s ^ (^shreg) ^ bus.cfg_parity[1];
        end
    end

    // Publish the frame one cycle after the mid-stop sample; data and flags hold until the next frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.rxvalid    <= 1'b0;
            bus.rxdout     <= '0;
            bus.parity_err <= 1'b0;
            bus.frame_err  <= 1'b0;
        end else begin
            bus.rxvalid <= stop_smp;
            if (stop_smp) begin
                bus.rxdout     <= shreg;
                bus.parity_err <= perr & bus.cfg_parity[0];
                bus.frame_err  <= ~rx_s;
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_core.sv
// tb/tb_uart_rx_core.sv - directed self-checking bench for uart_rx_core
module tb_uart_rx_core;
    localparam int BIT_CLKS = 48;

    logic clk;
    logic rst;
    uart_rx_core_if bus();

    uart_rx_core #(.BUADRATE(1000000), .CLKFRQ(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    logic [7:0] got_d [$];
    logic       got_p [$];
    logic       got_f [$];

    always @(negedge clk) begin
        if (!rst && bus.rxvalid) begin
            got_d.push_back(bus.rxdout);
            got_p.push_back(bus.parity_err);
            got_f.push_back(bus.frame_err);
        end
    end

    function automatic logic [7:0] gd(input int k);
        return (k < got_d.size()) ? got_d[k] : 8'hxx;
    endfunction
    function automatic logic gp(input int k);
        return (k < got_p.size()) ? got_p[k] : 1'bx;
    endfunction
    function automatic logic gf(input int k);
        return (k < got_f.size()) ? got_f[k] : 1'bx;
    endfunction

    task automatic clear_log();
        got_d.delete();
        got_p.delete();
        got_f.delete();
    endtask

    task automatic drive_bit(input logic b, input int n);
        bus.uart_rx = b;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic has_par, input logic par_bit,
                              input logic stop_val, input int n_stop);
        drive_bit(1'b0, BIT_CLKS);
        for (int i = 0; i < 8; i++) drive_bit(d[i], BIT_CLKS);
        if (has_par) drive_bit(par_bit, BIT_CLKS);
        drive_bit(stop_val, BIT_CLKS);
        for (int i = 1; i < n_stop; i++) drive_bit(1'b1, BIT_CLKS);
        bus.uart_rx = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_total++; if (bus.rxvalid !== 1'b0) $display("FAIL reset_rxvalid got %b want 0", bus.rxvalid); else n_pass++;
        n_total++; if (bus.rxdout !== 8'h00) $display("FAIL reset_rxdout got %h want 00", bus.rxdout); else n_pass++;
        n_total++; if (bus.parity_err !== 1'b0) $display("FAIL reset_parity_err got %b want 0", bus.parity_err); else n_pass++;
        n_total++; if (bus.frame_err !== 1'b0) $display("FAIL reset_frame_err got %b want 0", bus.frame_err); else n_pass++;
        rst = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_basic();
        clear_log();
        bus.cfg_parity = 2'b00; bus.cfg_stop_bits = 2'd0;
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 1);
        repeat (20) @(negedge clk);
        n_total++; if (got_d.size() !== 1) $display("FAIL basic_count got %0d want 1", got_d.size()); else n_pass++;
        n_total++; if (gd(0) !== 8'hA5) $display("FAIL basic_data got %h want a5", gd(0)); else n_pass++;
        n_total++; if (gp(0) !== 1'b0) $display("FAIL basic_perr got %b want 0", gp(0)); else n_pass++;
        n_total++; if (gf(0) !== 1'b0) $display("FAIL basic_ferr got %b want 0", gf(0)); else n_pass++;
    endtask

    task automatic test_even_parity();
        clear_log();
        bus.cfg_parity = 2'b01;
        send_frame(8'h07, 1'b1, 1'b1, 1'b1, 1);
        send_frame(8'h07, 1'b1, 1'b0, 1'b1, 1);
        repeat (20) @(negedge clk);
        n_total++; if (got_d.size() !== 2) $display("FAIL even_count got %0d want 2", got_d.size()); else n_pass++;
        n_total++; if (gd(0) !== 8'h07) $display("FAIL even_data0 got %h want 07", gd(0)); else n_pass++;
        n_total++; if (gp(0) !== 1'b0) $display("FAIL even_perr_good got %b want 0", gp(0)); else n_pass++;
        n_total++; if (gd(1) !== 8'h07) $display("FAIL even_data1 got %h want 07", gd(1)); else n_pass++;
        n_total++; if (gp(1) !== 1'b1) $display("FAIL even_perr_bad got %b want 1", gp(1)); else n_pass++;
    endtask

    task automatic test_odd_parity_frame_err();
        clear_log();
        bus.cfg_parity = 2'b11;
        send_frame(8'h00, 1'b1, 1'b1, 1'b1, 1);
        // Stop bit low, then the line stays low (break) for several more bit times
        send_frame(8'h00, 1'b1, 1'b1, 1'b0, 1);
        drive_bit(1'b0, 4 * BIT_CLKS);
        drive_bit(1'b1, 2 * BIT_CLKS);
        n_total++; if (got_d.size() !== 2) $display("FAIL odd_count got %0d want 2", got_d.size()); else n_pass++;
        n_total++; if (gp(0) !== 1'b0) $display("FAIL odd_perr got %b want 0", gp(0)); else n_pass++;
        n_total++; if (gf(0) !== 1'b0) $display("FAIL odd_ferr0 got %b want 0", gf(0)); else n_pass++;
        n_total++; if (gf(1) !== 1'b1) $display("FAIL odd_ferr1 got %b want 1", gf(1)); else n_pass++;
        n_total++; if (gd(1) !== 8'h00) $display("FAIL odd_data1 got %h want 00", gd(1)); else n_pass++;
        n_total++; if (gp(1) !== 1'b0) $display("FAIL odd_perr1 got %b want 0", gp(1)); else n_pass++;
    endtask

    task automatic test_glitch();
        clear_log();
        bus.cfg_parity = 2'b00;
        drive_bit(1'b0, 20);
        drive_bit(1'b1, 3 * BIT_CLKS);
        n_total++; if (got_d.size() !== 0) $display("FAIL glitch_count got %0d want 0", got_d.size()); else n_pass++;
        send_frame(8'h3C, 1'b0, 1'b0, 1'b1, 1);
        repeat (20) @(negedge clk);
        n_total++; if (got_d.size() !== 1) $display("FAIL glitch_after_count got %0d want 1", got_d.size()); else n_pass++;
        n_total++; if (gd(0) !== 8'h3C) $display("FAIL glitch_after_data got %h want 3c", gd(0)); else n_pass++;
        n_total++; if (gf(0) !== 1'b0) $display("FAIL glitch_after_ferr got %b want 0", gf(0)); else n_pass++;
    endtask

    task automatic test_back_to_back();
        clear_log();
        bus.cfg_parity = 2'b00; bus.cfg_stop_bits = 2'd2;
        send_frame(8'h11, 1'b0, 1'b0, 1'b1, 2);
        send_frame(8'h22, 1'b0, 1'b0, 1'b1, 2);
        send_frame(8'h33, 1'b0, 1'b0, 1'b1, 2);
        repeat (20) @(negedge clk);
        n_total++; if (got_d.size() !== 3) $display("FAIL b2b_count got %0d want 3", got_d.size()); else n_pass++;
        n_total++; if (gd(0) !== 8'h11) $display("FAIL b2b_data0 got %h want 11", gd(0)); else n_pass++;
        n_total++; if (gd(1) !== 8'h22) $display("FAIL b2b_data1 got %h want 22", gd(1)); else n_pass++;
        n_total++; if (gd(2) !== 8'h33) $display("FAIL b2b_data2 got %h want 33", gd(2)); else n_pass++;
        n_total++; if (gf(2) !== 1'b0) $display("FAIL b2b_ferr2 got %b want 0", gf(2)); else n_pass++;
        bus.cfg_stop_bits = 2'd0;
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] d;
        clear_log();
        d = 8'hFF;
        drive_bit(1'b0, BIT_CLKS);
        for (int i = 0; i < 4; i++) drive_bit(d[i], BIT_CLKS);
        drive_bit(d[4], BIT_CLKS / 2);
        rst = 1'b1;
        bus.uart_rx = 1'b1;
        #1;
        n_total++; if (bus.rxdout !== 8'h00) $display("FAIL midrst_rxdout got %h want 00", bus.rxdout); else n_pass++;
        n_total++; if (bus.rxvalid !== 1'b0) $display("FAIL midrst_rxvalid got %b want 0", bus.rxvalid); else n_pass++;
        n_total++; if (bus.parity_err !== 1'b0) $display("FAIL midrst_perr got %b want 0", bus.parity_err); else n_pass++;
        n_total++; if (bus.frame_err !== 1'b0) $display("FAIL midrst_ferr got %b want 0", bus.frame_err); else n_pass++;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        drive_bit(1'b1, 12 * BIT_CLKS);
        n_total++; if (got_d.size() !== 0) $display("FAIL midrst_count got %0d want 0", got_d.size()); else n_pass++;
        send_frame(8'h5A, 1'b0, 1'b0, 1'b1, 1);
        repeat (20) @(negedge clk);
        n_total++; if (got_d.size() !== 1) $display("FAIL midrst_after_count got %0d want 1", got_d.size()); else n_pass++;
        n_total++; if (gd(0) !== 8'h5A) $display("FAIL midrst_after_data got %h want 5a", gd(0)); else n_pass++;
    endtask

    initial begin
        rst = 1'b1;
        bus.uart_rx = 1'b1;
        bus.cfg_parity = 2'b00;
        bus.cfg_stop_bits = 2'd0;
        test_reset();
        test_basic();
        test_even_parity();
        test_odd_parity_frame_err();
        test_glitch();
        test_back_to_back();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
